axi_stream_pkt_gen: RTL and testbench
=====================================

// Module: axi_stream_pkt_gen
// PURPOSE
//   Parametrised AXI-Stream traffic-generator master: emits NUM_PKTS packets of PKT_BEATS
//   beats with a counting payload. Supports a partial last-beat keep, inter-packet gaps and
//   periodic throttle windows. Holds TVALID and payload stable under backpressure.
//   Drives DUT stream inputs (e.g. header inserter) in block-level benches and in BIST.
// PARAMETERS
//   DATA_WIDTH     32              payload width, bits (multiple of 8, >= 8)
//   KEEP_WIDTH     DATA_WIDTH/8    keep width, bytes
//   PKT_BEATS      100             beats per packet (>= 1)
//   LAST_BYTES     KEEP_WIDTH      valid bytes on last beat (1..KEEP_WIDTH)
//   NUM_PKTS       0               packets to send; 0 = unbounded
//   GAP_CYCLES     0               forced idle cycles after each last beat
//   PAUSE_PERIOD   66              throttle period, cycles (>= 1)
//   PAUSE_DURATION 0               throttle window length; 0 = disabled, < PAUSE_PERIOD
// PORTS
//   clk        in   1           clock, all logic on rising edge
//   rst        in   1           synchronous reset, active high
//   enable     in   1           start/continue generating; sampled at packet boundaries
//   m_valid    out  1           TVALID
//   m_data     out  DATA_WIDTH  TDATA
//   m_keep     out  KEEP_WIDTH  TKEEP
//   m_last     out  1           TLAST
//   m_ready    in   1           TREADY
//   pkt_count  out  32          completed packets (wraps at 2^32)
//   done       out  1           sticky: NUM_PKTS packets sent (never set if NUM_PKTS=0)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, beat/payload/pause counters 0. rst overrides all and
//   takes effect mid-packet; the partial packet is abandoned and not counted.
// - All outputs are registered. Handshake = m_valid & m_ready in the same cycle.
// - Payload: m_data = running beat counter mod 2^DATA_WIDTH. It counts across packets,
//   advances only on a handshake and clears only on rst.
// - m_keep = all ones, except the last beat: lower LAST_BYTES bits set, the rest 0.
// - m_last = 1 on beat index PKT_BEATS-1 only. PKT_BEATS=1 gives m_last on every beat.
// - AXI rule: once m_valid=1, m_valid/m_data/m_keep/m_last are held until a handshake.
//   Neither pause nor enable may drop m_valid or change the beat before it is accepted.
// - Pause: free-running cycle counter cyc, 0..PAUSE_PERIOD-1, wraps; starts at 0 after rst.
//   The window is active when cyc >= PAUSE_PERIOD-PAUSE_DURATION. No new beat is presented
//   in a window cycle; a pending unaccepted beat stays valid through the window.
// - FSM: IDLE, SEND, GAP, DONE.
//   IDLE: enable=1 at cycle t -> SEND. First beat valid at t+1 unless that cycle is a
//     pause-window cycle.
//   SEND, non-last handshake at t -> next beat valid at t+1 if not paused (full rate).
//   SEND, last handshake at t -> pkt_count+1 at t+1, then the first matching rule applies:
//     count reached NUM_PKTS -> DONE, done=1 at t+1;
//     GAP_CYCLES>0 -> GAP, m_valid=0 for exactly GAP_CYCLES cycles;
//     enable=0 -> IDLE;
//     else -> next packet first beat at t+1 if not paused.
//   GAP: on expiry -> SEND if enable=1, else IDLE.
//   DONE: m_valid=0; held until rst.
// - enable=0 mid-packet does not truncate the packet. It is honoured after the last handshake.
// - The pause window and GAP overlap independently. A gap expiring inside a window waits
//   for the window to end.
// TESTING (DATA_WIDTH=32, PKT_BEATS=4, LAST_BYTES=2, NUM_PKTS=2, GAP_CYCLES=3 unless noted)
// 1 rst=1 for 3 cycles, enable=1 -> all outputs 0, done=0; m_valid=1 the cycle after release.
// 2 m_ready=1 constant -> data 0,1,2,3 with keep F,F,F,3 and m_last on data 3.
//   Then exactly 3 idle cycles, then data 4..7. done=1 and pkt_count=2 after data 7.
// 3 m_ready low for 5 cycles during data=2 -> data/keep/last stable, no beat skipped or
//   repeated; data=3 follows the accepting cycle.
// 4 PKT_BEATS=100, NUM_PKTS=0, PAUSE_PERIOD=10, PAUSE_DURATION=4, m_ready=1 -> m_valid=0 on
//   cyc 6..9 each period. With m_ready=0 entering cyc 6, m_valid stays high through 6..9.
// 5 enable dropped at data=1 -> data 2,3 still sent, then m_valid=0 in IDLE.
//   Re-enable -> resumes at data 4 after the gap.
// 6 rst pulse at data=2 -> outputs 0 next cycle, pkt_count=0; restart emits data 0.

Source files
------------

// File: rtl/axi_stream_pkt_gen_if.sv
// AXI-Stream bundle carrying the generator's beats; master drives, slave sinks.
interface axi_stream_pkt_gen_if #(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic [KEEP_WIDTH-1:0] m_keep;
   logic                  m_last;
   logic                  m_ready;

   modport master (output m_valid, m_data, m_keep, m_last, input m_ready);
   modport slave  (input m_valid, m_data, m_keep, m_last, output m_ready);
endinterface

// File: rtl/axi_stream_pkt_gen.sv
// AXI-Stream traffic generator: fixed-length packets of a counting payload with
// optional partial last keep, inter-packet gaps and periodic throttle windows.
module axi_stream_pkt_gen #(
   parameter int DATA_WIDTH     = 32,
   parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
   parameter int PKT_BEATS      = 100,
   parameter int LAST_BYTES     = KEEP_WIDTH,
   parameter int NUM_PKTS       = 0,
   parameter int GAP_CYCLES     = 0,
   parameter int PAUSE_PERIOD   = 66,
   parameter int PAUSE_DURATION = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   axi_stream_pkt_gen_if.master        m_axis,
   output logic [31:0]                 pkt_count,
   output logic                        done
);

   localparam int BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
   localparam int CYC_W  = (PAUSE_PERIOD > 1) ? $clog2(PAUSE_PERIOD) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BEAT_W-1:0]     LAST_IDX   = BEAT_W'(PKT_BEATS - 1);
   localparam logic [BEAT_W-1:0]     BEAT_ONE   = BEAT_W'(1);
   localparam logic [CYC_W-1:0]      CYC_MAX    = CYC_W'(PAUSE_PERIOD - 1);
   localparam logic [CYC_W-1:0]      CYC_ONE    = CYC_W'(1);
   localparam logic [CYC_W:0]        WIN_START  = (CYC_W + 1)'(PAUSE_PERIOD - PAUSE_DURATION);
   localparam logic [GAP_W-1:0]      GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0]      GAP_ONE    = GAP_W'(1);
   localparam logic [DATA_WIDTH-1:0] DATA_ONE   = DATA_WIDTH'(1);
   localparam logic [31:0]           PKT_LIMIT  = 32'(NUM_PKTS);
   localparam bit                    HAS_LIMIT  = (NUM_PKTS != 0);
   localparam bit                    HAS_GAP    = (GAP_CYCLES != 0);

   function automatic logic [KEEP_WIDTH-1:0] last_keep_mask();
      logic [KEEP_WIDTH-1:0] m;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         m[i] = (i < LAST_BYTES);
      end
      return m;
   endfunction

   localparam logic [KEEP_WIDTH-1:0] LAST_KEEP = last_keep_mask();

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic [KEEP_WIDTH-1:0] keep_q,  keep_d;
   logic                  last_q,  last_d;
   logic [BEAT_W-1:0]     beat_q,  beat_d;
   logic [GAP_W-1:0]      gap_q,   gap_d;
   logic [CYC_W-1:0]      cyc_q,   cyc_d;
   logic [31:0]           pkt_q,   pkt_d;
   logic                  done_q,  done_d;

   logic                  hs_s;
   logic                  beat_last_s;
   logic                  window_next_s;
   logic [31:0]           pkt_inc_s;

   assign hs_s          = valid_q & m_axis.m_ready;
   assign beat_last_s   = (beat_q == LAST_IDX);
   assign pkt_inc_s     = pkt_q + 32'd1;
   // Throttle is judged on the cycle a new beat would become visible.
   assign window_next_s = ({1'b0, cyc_d} >= WIN_START);

   // Next-state, beat sequencing and output staging.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      data_d  = data_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      pkt_d   = pkt_q;
      done_d  = done_q;
      keep_d  = {KEEP_WIDTH{1'b0}};
      last_d  = 1'b0;

      if (cyc_q == CYC_MAX) begin
         cyc_d = {CYC_W{1'b0}};
      end else begin
         cyc_d = cyc_q + CYC_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_SEND;
               valid_d = !window_next_s;
            end else begin
               valid_d = 1'b0;
            end
         end
         ST_SEND: begin
            if (hs_s) begin
               data_d = data_q + DATA_ONE;
               if (beat_last_s) begin
                  beat_d = {BEAT_W{1'b0}};
                  pkt_d  = pkt_inc_s;
                  if (HAS_LIMIT && (pkt_inc_s == PKT_LIMIT)) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                     valid_d = 1'b0;
                  end else if (HAS_GAP) begin
                     state_d = ST_GAP;
                     gap_d   = GAP_LOAD;
                     valid_d = 1'b0;
                  end else if (!enable) begin
                     state_d = ST_IDLE;
                     valid_d = 1'b0;
                  end else begin
                     valid_d = !window_next_s;
                  end
               end else begin
                  beat_d  = beat_q + BEAT_ONE;
                  valid_d = !window_next_s;
               end
            end else if (!valid_q) begin
               valid_d = !window_next_s;
            end else begin
               valid_d = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_q == {GAP_W{1'b0}}) begin
               if (enable) begin
                  state_d = ST_SEND;
                  valid_d = !window_next_s;
               end else begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
               end
            end else begin
               gap_d   = gap_q - GAP_ONE;
               valid_d = 1'b0;
            end
         end
         ST_DONE: begin
            valid_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase

      if (!valid_d) begin
         keep_d = {KEEP_WIDTH{1'b0}};
         last_d = 1'b0;
      end else if (beat_d == LAST_IDX) begin
         keep_d = LAST_KEEP;
         last_d = 1'b1;
      end else begin
         keep_d = {KEEP_WIDTH{1'b1}};
         last_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         data_q  <= {DATA_WIDTH{1'b0}};
         keep_q  <= {KEEP_WIDTH{1'b0}};
         last_q  <= 1'b0;
         beat_q  <= {BEAT_W{1'b0}};
         gap_q   <= {GAP_W{1'b0}};
         cyc_q   <= {CYC_W{1'b0}};
         pkt_q   <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         cyc_q   <= cyc_d;
         pkt_q   <= pkt_d;
         done_q  <= done_d;
      end
   end

   assign m_axis.m_valid = valid_q;
   assign m_axis.m_data  = data_q;
   assign m_axis.m_keep  = keep_q;
   assign m_axis.m_last  = last_q;
   assign pkt_count      = pkt_q;
   assign done           = done_q;

endmodule

// File: tb/tb_axi_stream_pkt_gen.sv
// Bench for axi_stream_pkt_gen: four configurations against a transaction-level
// model, plus directed scenarios with hand-computed expectations.
module tb_axi_stream_pkt_gen;

   localparam int NI = 4;
   localparam int DW = 32;

   localparam int P0_PB = 4,   P0_LB = 2, P0_NP = 2, P0_GAP = 3, P0_PP = 66, P0_PD = 0;
   localparam int P1_PB = 100, P1_LB = 4, P1_NP = 0, P1_GAP = 0, P1_PP = 10, P1_PD = 4;
   localparam int P2_PB = 5,   P2_LB = 3, P2_NP = 0, P2_GAP = 2, P2_PP = 7,  P2_PD = 3;
   localparam int P3_PB = 1,   P3_LB = 1, P3_NP = 5, P3_GAP = 0, P3_PP = 5,  P3_PD = 1;

   int pb_c  [NI] = '{P0_PB,  P1_PB,  P2_PB,  P3_PB};
   int lb_c  [NI] = '{P0_LB,  P1_LB,  P2_LB,  P3_LB};
   int np_c  [NI] = '{P0_NP,  P1_NP,  P2_NP,  P3_NP};
   int gap_c [NI] = '{P0_GAP, P1_GAP, P2_GAP, P3_GAP};
   int pp_c  [NI] = '{P0_PP,  P1_PP,  P2_PP,  P3_PP};
   int pd_c  [NI] = '{P0_PD,  P1_PD,  P2_PD,  P3_PD};
   int rrate [NI] = '{80, 600, 500, 60};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0] rst_v, en_v, rdy_v;
   logic [NI-1:0] val_v, last_v, done_v;
   logic [31:0]   dat_v [NI];
   logic [3:0]    kp_v  [NI];
   logic [31:0]   pkt_v [NI];

   int checks   = 0;
   int failures = 0;

   axi_stream_pkt_gen_if #(.DATA_WIDTH(DW)) ax0 ();
   axi_stream_pkt_gen_if #(.DATA_WIDTH(DW)) ax1 ();
   axi_stream_pkt_gen_if #(.DATA_WIDTH(DW)) ax2 ();
   axi_stream_pkt_gen_if #(.DATA_WIDTH(DW)) ax3 ();

   assign ax0.m_ready = rdy_v[0];
   assign ax1.m_ready = rdy_v[1];
   assign ax2.m_ready = rdy_v[2];
   assign ax3.m_ready = rdy_v[3];

   assign val_v[0] = ax0.m_valid; assign dat_v[0] = ax0.m_data; assign kp_v[0] = ax0.m_keep; assign last_v[0] = ax0.m_last;
   assign val_v[1] = ax1.m_valid; assign dat_v[1] = ax1.m_data; assign kp_v[1] = ax1.m_keep; assign last_v[1] = ax1.m_last;
   assign val_v[2] = ax2.m_valid; assign dat_v[2] = ax2.m_data; assign kp_v[2] = ax2.m_keep; assign last_v[2] = ax2.m_last;
   assign val_v[3] = ax3.m_valid; assign dat_v[3] = ax3.m_data; assign kp_v[3] = ax3.m_keep; assign last_v[3] = ax3.m_last;

   axi_stream_pkt_gen #(.DATA_WIDTH(DW), .PKT_BEATS(P0_PB), .LAST_BYTES(P0_LB), .NUM_PKTS(P0_NP),
                        .GAP_CYCLES(P0_GAP), .PAUSE_PERIOD(P0_PP), .PAUSE_DURATION(P0_PD))
      dut0 (.clk(clk), .rst(rst_v[0]), .enable(en_v[0]), .m_axis(ax0), .pkt_count(pkt_v[0]), .done(done_v[0]));
   axi_stream_pkt_gen #(.DATA_WIDTH(DW), .PKT_BEATS(P1_PB), .LAST_BYTES(P1_LB), .NUM_PKTS(P1_NP),
                        .GAP_CYCLES(P1_GAP), .PAUSE_PERIOD(P1_PP), .PAUSE_DURATION(P1_PD))
      dut1 (.clk(clk), .rst(rst_v[1]), .enable(en_v[1]), .m_axis(ax1), .pkt_count(pkt_v[1]), .done(done_v[1]));
   axi_stream_pkt_gen #(.DATA_WIDTH(DW), .PKT_BEATS(P2_PB), .LAST_BYTES(P2_LB), .NUM_PKTS(P2_NP),
                        .GAP_CYCLES(P2_GAP), .PAUSE_PERIOD(P2_PP), .PAUSE_DURATION(P2_PD))
      dut2 (.clk(clk), .rst(rst_v[2]), .enable(en_v[2]), .m_axis(ax2), .pkt_count(pkt_v[2]), .done(done_v[2]));
   axi_stream_pkt_gen #(.DATA_WIDTH(DW), .PKT_BEATS(P3_PB), .LAST_BYTES(P3_LB), .NUM_PKTS(P3_NP),
                        .GAP_CYCLES(P3_GAP), .PAUSE_PERIOD(P3_PP), .PAUSE_DURATION(P3_PD))
      dut3 (.clk(clk), .rst(rst_v[3]), .enable(en_v[3]), .m_axis(ax3), .pkt_count(pkt_v[3]), .done(done_v[3]));

   // Model: beats accepted so far determine payload, keep, last, count and done;
   // only the timing of presentation needs a little state.
   int unsigned mn     [NI];
   bit          mpend  [NI];
   bit          marmed [NI];
   int          mgap   [NI];
   int          mk     [NI];

   function automatic bit in_window(input int i, input int c);
      return (pd_c[i] > 0) && ((c % pp_c[i]) >= (pp_c[i] - pd_c[i]));
   endfunction

   function automatic bit model_done(input int i);
      return (np_c[i] != 0) && ((mn[i] / pb_c[i]) >= np_c[i]);
   endfunction

   initial begin
      for (int i = 0; i < NI; i++) begin
         mn[i] = 0; mpend[i] = 0; marmed[i] = 0; mgap[i] = -1; mk[i] = 0;
      end
      forever begin
         @(posedge clk);
         for (int i = 0; i < NI; i++) begin
            if (rst_v[i]) begin
               mn[i] = 0; mpend[i] = 0; marmed[i] = 0; mgap[i] = -1; mk[i] = 0;
            end else begin
               if (mpend[i] && rdy_v[i]) begin
                  mn[i]++;
                  mpend[i] = 0;
                  if ((mn[i] % pb_c[i]) == 0) begin
                     if (model_done(i)) marmed[i] = 0;
                     else if (gap_c[i] > 0) begin mgap[i] = mk[i] + gap_c[i]; marmed[i] = 0; end
                     else marmed[i] = en_v[i];
                  end else begin
                     marmed[i] = 1;
                  end
               end else if (!mpend[i] && !marmed[i] && !model_done(i)) begin
                  if (mgap[i] >= 0) begin
                     if (mk[i] == mgap[i]) begin marmed[i] = en_v[i]; mgap[i] = -1; end
                  end else begin
                     marmed[i] = en_v[i];
                  end
               end
               if (!mpend[i] && marmed[i] && !in_window(i, mk[i] + 1)) begin
                  mpend[i] = 1; marmed[i] = 0;
               end
               mk[i]++;
            end
         end
      end
   end

   task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", name, i, $time, got, exp);
      end
   endtask

   // Per-cycle comparison of every instance against the model.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            int unsigned idx;
            logic [3:0] ek;
            idx = mn[i] % pb_c[i];
            ek  = (idx == pb_c[i] - 1) ? 4'((1 << lb_c[i]) - 1) : 4'hF;
            chk("model_valid", i, {31'd0, val_v[i]}, {31'd0, mpend[i]});
            if (mpend[i]) begin
               chk("model_data", i, dat_v[i], mn[i]);
               chk("model_keep", i, {28'd0, kp_v[i]}, {28'd0, ek});
               chk("model_last", i, {31'd0, last_v[i]}, {31'd0, (idx == pb_c[i] - 1)});
            end
            chk("model_pkt", i, pkt_v[i], mn[i] / pb_c[i]);
            chk("model_done", i, {31'd0, done_v[i]}, {31'd0, model_done(i)});
         end
      end
   end

   task automatic wait_data(input int i, input logic [31:0] d);
      int n;
      n = 0;
      while (!(val_v[i] && dat_v[i] == d) && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 40) begin
         failures++;
         $display("FAIL wait_data inst=%0d got=timeout exp=data %0h", i, d);
      end
   endtask

   task automatic beat0(input string name, input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
      chk({name, "_valid"}, 0, {31'd0, val_v[0]}, {31'd0, v});
      if (v) begin
         chk({name, "_data"}, 0, dat_v[0], d);
         chk({name, "_keep"}, 0, {28'd0, kp_v[0]}, {28'd0, k});
         chk({name, "_last"}, 0, {31'd0, last_v[0]}, {31'd0, l});
      end
   endtask

   initial begin
      logic [11:0]  t2_v;
      logic [31:0]  held;
      t2_v  = 12'b111100011110;
      rst_v = '1; en_v = '1; rdy_v = '1;
      repeat (3) @(negedge clk);

      // Reset state.
      chk("rst_valid", 0, {31'd0, val_v[0]}, 32'd0);
      chk("rst_data",  0, dat_v[0], 32'd0);
      chk("rst_keep",  0, {28'd0, kp_v[0]}, 32'd0);
      chk("rst_last",  0, {31'd0, last_v[0]}, 32'd0);
      chk("rst_pkt",   0, pkt_v[0], 32'd0);
      chk("rst_done",  0, {31'd0, done_v[0]}, 32'd0);

      // Two packets at full rate with a 3-cycle gap, then done.
      rst_v[0] = 1'b0;
      for (int j = 0; j < 12; j++) begin
         int d;
         @(negedge clk);
         d = (j < 4) ? j : j - 3;
         beat0("seq", t2_v[11-j], 32'(d), ((d % 4) == 3) ? 4'h3 : 4'hF, (d % 4) == 3);
      end
      chk("seq_done", 0, {31'd0, done_v[0]}, 32'd1);
      chk("seq_pkt",  0, pkt_v[0], 32'd2);
      repeat (2) @(negedge clk);
      chk("done_hold", 0, {31'd0, val_v[0]}, 32'd0);

      // Backpressure on data 2.
      rst_v[0] = 1'b1; @(negedge clk); rst_v[0] = 1'b0;
      wait_data(0, 32'd2);
      rdy_v[0] = 1'b0;
      repeat (5) begin
         @(negedge clk);
         beat0("stall", 1'b1, 32'd2, 4'hF, 1'b0);
      end
      rdy_v[0] = 1'b1;
      @(negedge clk);
      beat0("after_stall", 1'b1, 32'd3, 4'h3, 1'b1);

      // Enable dropped mid-packet, then re-enabled.
      rst_v[0] = 1'b1; @(negedge clk); rst_v[0] = 1'b0;
      wait_data(0, 32'd1);
      en_v[0] = 1'b0;
      @(negedge clk); beat0("en_off_d2", 1'b1, 32'd2, 4'hF, 1'b0);
      @(negedge clk); beat0("en_off_d3", 1'b1, 32'd3, 4'h3, 1'b1);
      repeat (6) begin
         @(negedge clk); beat0("en_off_idle", 1'b0, 32'd0, 4'h0, 1'b0);
      end
      en_v[0] = 1'b1;
      @(negedge clk); beat0("re_enable", 1'b1, 32'd4, 4'hF, 1'b0);

      // Reset mid-packet in the second packet.
      wait_data(0, 32'd6);
      chk("pre_rst_pkt", 0, pkt_v[0], 32'd1);
      rst_v[0] = 1'b1;
      @(negedge clk);
      chk("midrst_valid", 0, {31'd0, val_v[0]}, 32'd0);
      chk("midrst_data",  0, dat_v[0], 32'd0);
      chk("midrst_pkt",   0, pkt_v[0], 32'd0);
      chk("midrst_keep",  0, {28'd0, kp_v[0]}, 32'd0);
      rst_v[0] = 1'b0;
      @(negedge clk);
      beat0("restart", 1'b1, 32'd0, 4'hF, 1'b0);

      // Throttle windows on cyc 6..9 of a 10-cycle period.
      rst_v[1] = 1'b0;
      held = 32'd0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (j <= 35) begin
            chk("pause_valid", 1, {31'd0, val_v[1]}, {31'd0, ((j % 10) < 6)});
         end else begin
            chk("pause_hold_valid", 1, {31'd0, val_v[1]}, 32'd1);
         end
         if (j == 35) begin
            held = dat_v[1];
            rdy_v[1] = 1'b0;
         end
         if (j > 35 && j < 40) chk("pause_hold_data", 1, dat_v[1], held);
         if (j == 39) rdy_v[1] = 1'b1;
         if (j == 40) chk("pause_resume_data", 1, dat_v[1], held + 32'd1);
      end

      // Randomised traffic on every configuration.
      rst_v = '0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            rdy_v[i] = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 3) en_v[i] = ~en_v[i];
            rst_v[i] = ($urandom_range(0, rrate[i]) == 0);
         end
      end
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
